// File: rtl/cpu_pkg.sv
// cpu_pkg: shared memory geometry defaults and the read-owner type used by the arbiter.
package cpu_pkg;
   localparam int CPU_ADDR_WIDTH = 12;
   localparam int CPU_DATA_WIDTH = 16;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} rd_owner_e;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: counts consecutive denied fetch cycles, saturating at LIMIT; starved flags saturation.
module arb_starve_cnt #(
   parameter int LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic if_gnt,
   output logic starved
);
   localparam int CW = $clog2(LIMIT + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (if_gnt) cnt <= '0;
      else if (if_req && cnt != CW'(LIMIT)) cnt <= cnt + 1'b1;
   assign starved = cnt == CW'(LIMIT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter for a single-port synchronous memory; data wins conflicts.
// Define MEM_ARB_FAIRNESS_EN to let a starved fetch port win after STARVE_LIMIT denied cycles.
module mem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH   = CPU_ADDR_WIDTH,
   parameter int DATA_WIDTH   = CPU_DATA_WIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_en,
   output logic                  mem_rd_en,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   input  logic [DATA_WIDTH-1:0] mem_dout
);
   rd_owner_e owner, owner_nxt;
   logic starved, if_win;
   logic [DATA_WIDTH-1:0] if_rdata_q, d_rdata_q;
   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be at least 1");
   end
`ifdef MEM_ARB_FAIRNESS_EN
   arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk(clk), .rst(rst), .if_req(if_req), .if_gnt(if_gnt), .starved(starved)
   );
`else
   assign starved = 1'b0;
`endif
   always_comb begin
      if_win    = if_req && (!d_req || starved);
      if_gnt    = !rst && if_win;
      d_gnt     = !rst && d_req && !if_win;
      mem_en    = if_gnt || d_gnt;
      mem_rd_en = if_gnt || (d_gnt && !d_we);
      mem_wr_en = d_gnt && d_we;
      mem_addr  = if_gnt ? if_addr : d_gnt ? d_addr : '0;
      mem_din   = mem_wr_en ? d_wdata : '0;
      owner_nxt = if_gnt ? OWN_IF : (d_gnt && !d_we) ? OWN_D : OWN_NONE;
   end
   // Async reset of owner drops any read already in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= OWN_NONE;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         owner <= owner_nxt;
         if (owner == OWN_IF) if_rdata_q <= mem_dout;
         if (owner == OWN_D) d_rdata_q <= mem_dout;
      end
   end
   assign if_rvalid = owner == OWN_IF;
   assign d_rvalid  = owner == OWN_D;
   assign if_rdata  = if_rvalid ? mem_dout : if_rdata_q;
   assign d_rdata   = d_rvalid ? mem_dout : d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench with a behavioural synchronous memory.
module tb_mem_arbiter;
   logic        clk = 1'b0, rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [11:0] if_addr;
   logic [15:0] if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [11:0] d_addr;
   logic [15:0] d_wdata, d_rdata;
   logic        mem_en, mem_rd_en, mem_wr_en;
   logic [11:0] mem_addr;
   logic [15:0] mem_din, mem_dout;
   logic [15:0] mem [0:4095];
   int n_assert = 0, n_fail = 0;
`ifdef MEM_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en && mem_wr_en) mem[mem_addr] <= mem_din;
      if (mem_en && mem_rd_en) mem_dout <= mem[mem_addr];
   end

   function automatic logic [15:0] exp_word(input int a);
      return 16'((a * 7) ^ 16'h5A00);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = exp_word(i);
      rst = 1'b1; if_req = 1'b1; if_addr = 12'h010;
      d_req = 1'b1; d_we = 1'b1; d_addr = 12'h055; d_wdata = 16'h1234;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_mem_en", {mem_en, mem_rd_en, mem_wr_en}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
      chk("rst_rdata", {if_rdata, d_rdata}, 0);
      // fetch only
      rst = 1'b0; d_req = 1'b0; d_we = 1'b0; #1;
      chk("f_gnt", {if_gnt, d_gnt}, 2'b10);
      chk("f_mem", {mem_en, mem_rd_en, mem_wr_en}, 3'b110);
      chk("f_addr", mem_addr, 12'h010);
      tick(); if_req = 1'b0; #1;
      chk("f_rvalid", {if_rvalid, d_rvalid}, 2'b10);
      chk("f_rdata", if_rdata, exp_word('h010));
      chk("f_idle_mem_en", {mem_en, mem_rd_en, mem_wr_en}, 0);
      tick();
      chk("f_rvalid_once", if_rvalid, 0);
      chk("f_rdata_hold", if_rdata, exp_word('h010));
      // conflict
      if_req = 1'b1; if_addr = 12'h020; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h100; #1;
      chk("c_gnt", {if_gnt, d_gnt}, 2'b01);
      chk("c_addr", mem_addr, 12'h100);
      tick(); d_req = 1'b0; #1;
      chk("c_rvalid", {if_rvalid, d_rvalid}, 2'b01);
      chk("c_d_rdata", d_rdata, exp_word('h100));
      chk("c_if_gnt_after", {if_gnt, d_gnt}, 2'b10);
      chk("c_if_addr", mem_addr, 12'h020);
      tick(); if_req = 1'b0; #1;
      chk("c_if_rvalid", {if_rvalid, d_rvalid}, 2'b10);
      chk("c_if_rdata", if_rdata, exp_word('h020));
      tick();
      // data write then fetch-back
      d_req = 1'b1; d_we = 1'b1; d_addr = 12'h200; d_wdata = 16'hBEEF; #1;
      chk("w_gnt", {if_gnt, d_gnt}, 2'b01);
      chk("w_mem", {mem_en, mem_rd_en, mem_wr_en}, 3'b101);
      chk("w_din", mem_din, 16'hBEEF);
      chk("w_addr", mem_addr, 12'h200);
      tick(); d_req = 1'b0; d_we = 1'b0; #1;
      chk("w_no_rvalid", {if_rvalid, d_rvalid}, 0);
      chk("w_d_rdata_hold", d_rdata, exp_word('h100));
      if_req = 1'b1; if_addr = 12'h200;
      tick(); if_req = 1'b0; #1;
      chk("w_readback", {if_rvalid, if_rdata}, {1'b1, 16'hBEEF});
      tick();
      // sustained conflict: fairness pattern
      if_req = 1'b1; if_addr = 12'h040; d_req = 1'b1; d_we = 1'b0; d_addr = 12'h041;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("fair_if_gnt_%0d", i), if_gnt, FAIR && (i % 5 == 4));
         chk($sformatf("fair_d_gnt_%0d", i), d_gnt, !(FAIR && (i % 5 == 4)));
         tick();
      end
      if_req = 1'b0; d_req = 1'b0;
      tick();
      // reset during an in-flight fetch read
      if_req = 1'b1; if_addr = 12'h030; #1;
      chk("r_gnt", if_gnt, 1);
      rst = 1'b1; #1;
      chk("r_gnt_off", {if_gnt, d_gnt}, 0);
      chk("r_mem_off", {mem_en, mem_rd_en, mem_wr_en, mem_addr}, 0);
      if_req = 1'b0;
      tick();
      chk("r_no_rvalid", {if_rvalid, d_rvalid}, 0);
      chk("r_rdata_zero", {if_rdata, d_rdata}, 0);
      rst = 1'b0; if_req = 1'b1; if_addr = 12'h031; #1;
      chk("r_regnt", {if_gnt, mem_addr}, {1'b1, 12'h031});
      tick(); if_req = 1'b0; #1;
      chk("r_rdata", {if_rvalid, if_rdata}, {1'b1, exp_word('h031)});
      tick();
      // streaming addresses 0..7
      for (int a = 0; a < 8; a++) begin
         if_req = 1'b1; if_addr = 12'(a); #1;
         chk($sformatf("s_gnt_%0d", a), {if_gnt, mem_addr}, {1'b1, 12'(a)});
         if (a > 0) chk($sformatf("s_data_%0d", a - 1), {if_rvalid, if_rdata}, {1'b1, exp_word(a - 1)});
         tick();
      end
      if_req = 1'b0; #1;
      chk("s_data_7", {if_rvalid, if_rdata}, {1'b1, exp_word(7)});
      tick();
      chk("s_end", if_rvalid, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
